// File: rtl/pistorm_pkg.sv
// Types and constants shared by the PiStorm bus arbiter and the 68000 cycle engine.
// Holds the arbiter state encoding, the bus-owner tag and the 68000 function-code values.
package pistorm_pkg;

    typedef enum logic [2:0] {
        ARB_IDLE    = 3'd0,
        ARB_RUN     = 3'd1,
        ARB_LOCK    = 3'd2,
        ARB_BG_WAIT = 3'd3,
        ARB_EXT_OWN = 3'd4
    } arb_state_t;

    typedef enum logic {
        OWNER_PI  = 1'b0,
        OWNER_EXT = 1'b1
    } bus_owner_t;

    localparam logic [2:0] FC_USER_DATA  = 3'd1;
    localparam logic [2:0] FC_USER_PROG  = 3'd2;
    localparam logic [2:0] FC_SUPER_DATA = 3'd5;
    localparam logic [2:0] FC_SUPER_PROG = 3'd6;
    localparam logic [2:0] FC_CPU_SPACE  = 3'd7;

    // Requester index width; a single requester still gets one index bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/m68k_bus_arbiter_rr_picker.sv
// Round-robin picker: first set request strictly after the pointer, wrapping to 0.
// Purely combinational; returns one-hot, binary index and an any-request flag.
module rr_picker
    import pistorm_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned W_IDX = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [W_IDX-1:0] ptr,
    output logic [N_REQ-1:0] pick_oh,
    output logic [W_IDX-1:0] pick_idx,
    output logic             pick_any
);

    always_comb begin
        int unsigned cand;
        pick_oh  = '0;
        pick_idx = '0;
        pick_any = 1'b0;
        cand     = 0;
        for (int unsigned off = 1; off <= N_REQ; off++) begin
            cand = (32'(ptr) + off) % N_REQ;
            if (!pick_any && req[cand[W_IDX-1:0]]) begin
                pick_any                   = 1'b1;
                pick_idx                   = cand[W_IDX-1:0];
                pick_oh[cand[W_IDX-1:0]]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/m68k_bus_arbiter.sv
// 68000 bus arbiter: round-robin among internal requesters plus the external BR/BG/BGACK
// handshake, with locked read-modify-write support and a bus-grant timeout.
module m68k_bus_arbiter
    import pistorm_pkg::*;
#(
    parameter int unsigned N_REQ      = 2,
    parameter int unsigned W_IDX      = idx_width(N_REQ),
    parameter int unsigned BG_TIMEOUT = 255
) (
    input  logic             PI_CLK,
    input  logic             PI_RST_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_lock,
    output logic [N_REQ-1:0] gnt,
    output logic [W_IDX-1:0] gnt_idx,
    output logic [N_REQ-1:0] done,
    output logic             eng_start,
    input  logic             eng_busy,
    input  logic             eng_done,
    input  logic             M68K_BR_n,
    input  logic             M68K_BGACK_n,
    output logic             M68K_BG_n,
    output logic             bus_drive,
    output logic             bg_timeout
);

    localparam int unsigned CNT_W = $clog2(BG_TIMEOUT + 1);

    arb_state_t       state;
    logic             br_meta, br_s;
    logic             bgack_meta, bgack_s;
    logic [W_IDX-1:0] rr_ptr;
    logic             ext_fair;
    logic [CNT_W-1:0] bg_cnt;

    logic [N_REQ-1:0] pick_oh;
    logic [W_IDX-1:0] pick_idx;
    logic             pick_any;
    logic             ext_held_off;

    always_ff @(posedge PI_CLK or negedge PI_RST_n) begin
        if (!PI_RST_n) begin
            br_meta    <= 1'b0;
            br_s       <= 1'b0;
            bgack_meta <= 1'b0;
            bgack_s    <= 1'b0;
        end else begin
            br_meta    <= ~M68K_BR_n;
            br_s       <= br_meta;
            bgack_meta <= ~M68K_BGACK_n;
            bgack_s    <= bgack_meta;
        end
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .W_IDX (W_IDX)
    ) u_picker (
        .req      (req),
        .ptr      (rr_ptr),
        .pick_oh  (pick_oh),
        .pick_idx (pick_idx),
        .pick_any (pick_any)
    );

    // After an external tenure, pending internal work goes ahead of a waiting BR.
    assign ext_held_off = ext_fair && (|req);

    always_ff @(posedge PI_CLK or negedge PI_RST_n) begin
        if (!PI_RST_n) begin
            state      <= ARB_IDLE;
            gnt        <= '0;
            gnt_idx    <= '0;
            done       <= '0;
            eng_start  <= 1'b0;
            M68K_BG_n  <= 1'b1;
            bus_drive  <= 1'b1;
            bg_timeout <= 1'b0;
            rr_ptr     <= W_IDX'(N_REQ - 1);
            ext_fair   <= 1'b0;
            bg_cnt     <= '0;
        end else begin
            done       <= '0;
            eng_start  <= 1'b0;
            bg_timeout <= 1'b0;

            case (state)
                ARB_IDLE: begin
                    if (done == '0 && !eng_busy) begin
                        if (bgack_s) begin
                            state     <= ARB_EXT_OWN;
                            bus_drive <= 1'b0;
                        end else if (br_s && !ext_held_off) begin
                            state     <= ARB_BG_WAIT;
                            M68K_BG_n <= 1'b0;
                            bg_cnt    <= '0;
                        end else if (pick_any) begin
                            state     <= ARB_RUN;
                            gnt       <= pick_oh;
                            gnt_idx   <= pick_idx;
                            eng_start <= 1'b1;
                            rr_ptr    <= pick_idx;
                            ext_fair  <= 1'b0;
                        end
                    end
                end

                ARB_RUN: begin
                    if (eng_done) begin
                        done <= gnt;
                        if (req_lock[gnt_idx]) begin
                            state <= ARB_LOCK;
                        end else begin
                            state <= ARB_IDLE;
                            gnt   <= '0;
                        end
                    end
                end

                ARB_LOCK: begin
                    if (req[gnt_idx] && !done[gnt_idx]) begin
                        state     <= ARB_RUN;
                        eng_start <= 1'b1;
                    end else if (!req_lock[gnt_idx]) begin
                        state <= ARB_IDLE;
                        gnt   <= '0;
                    end
                end

                ARB_BG_WAIT: begin
                    if (bgack_s) begin
                        state     <= ARB_EXT_OWN;
                        M68K_BG_n <= 1'b1;
                        bus_drive <= 1'b0;
                        bg_cnt    <= '0;
                    end else if (!br_s) begin
                        state     <= ARB_IDLE;
                        M68K_BG_n <= 1'b1;
                        bg_cnt    <= '0;
                    end else if (bg_cnt == CNT_W'(BG_TIMEOUT - 1)) begin
                        // Counter is one behind the number of cycles BG has been low.
                        state      <= ARB_IDLE;
                        M68K_BG_n  <= 1'b1;
                        bg_timeout <= 1'b1;
                        ext_fair   <= 1'b1;
                        bg_cnt     <= '0;
                    end else begin
                        bg_cnt <= bg_cnt + CNT_W'(1);
                    end
                end

                ARB_EXT_OWN: begin
                    if (!bgack_s) begin
                        state     <= ARB_IDLE;
                        bus_drive <= 1'b1;
                        ext_fair  <= 1'b1;
                    end
                end

                default: begin
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_m68k_bus_arbiter.sv
// Bench for m68k_bus_arbiter: directed scenarios against a cycle-level behavioural model,
// plus literal expectations on grant order, BG latency, timeout length and reset.
module tb_m68k_bus_arbiter;

    localparam int N       = 2;
    localparam int TMO     = 255;
    localparam int ENG_LAT = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = '0;
    logic [1:0] req_lock = '0;
    logic       eng_busy = 1'b0;
    logic       eng_done = 1'b0;
    logic       br_n = 1'b1;
    logic       bgack_n = 1'b1;

    logic [1:0] gnt;
    logic [0:0] gnt_idx;
    logic [1:0] done;
    logic       eng_start;
    logic       bg_n;
    logic       bus_drive;
    logic       bg_timeout;

    int n_cmp = 0;
    int n_bad = 0;
    int start_q[$];
    int done_q[$];

    always #5 clk = ~clk;

    m68k_bus_arbiter #(
        .N_REQ      (2),
        .W_IDX      (1),
        .BG_TIMEOUT (255)
    ) dut (
        .PI_CLK       (clk),
        .PI_RST_n     (rst_n),
        .req          (req),
        .req_lock     (req_lock),
        .gnt          (gnt),
        .gnt_idx      (gnt_idx),
        .done         (done),
        .eng_start    (eng_start),
        .eng_busy     (eng_busy),
        .eng_done     (eng_done),
        .M68K_BR_n    (br_n),
        .M68K_BGACK_n (bgack_n),
        .M68K_BG_n    (bg_n),
        .bus_drive    (bus_drive),
        .bg_timeout   (bg_timeout)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Engine stand-in: busy for ENG_LAT cycles after a start, then a one-cycle done.
    int eng_cnt = 0;
    always @(negedge clk) begin
        if (!rst_n) begin
            eng_cnt  = 0;
            eng_busy = 1'b0;
            eng_done = 1'b0;
        end else begin
            eng_done = 1'b0;
            if (eng_cnt != 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    eng_done = 1'b1;
                    eng_busy = 1'b0;
                end
            end else if (eng_start) begin
                eng_cnt  = ENG_LAT;
                eng_busy = 1'b1;
            end
        end
    end

    // Behavioural model of who owns the bus and what the arbiter announces each cycle.
    typedef enum {M_FREE, M_CYCLE, M_HELD, M_OFFER, M_EXT} mmode_e;
    mmode_e   m_mode;
    bit [1:0] m_br_pipe, m_ack_pipe;
    int       m_ptr, m_idx, m_bglow;
    bit       m_fair;
    bit [1:0] m_gnt, m_done;
    bit       m_start, m_bg_n, m_drive, m_tmo;

    task automatic model_reset();
        m_mode     = M_FREE;
        m_br_pipe  = '0;
        m_ack_pipe = '0;
        m_ptr      = N - 1;
        m_idx      = 0;
        m_bglow    = 0;
        m_fair     = 1'b0;
        m_gnt      = '0;
        m_done     = '0;
        m_start    = 1'b0;
        m_bg_n     = 1'b1;
        m_drive    = 1'b1;
        m_tmo      = 1'b0;
    endtask

    task automatic model_step();
        bit       br_s, ack_s, nstart, ntmo;
        bit [1:0] ndone;
        br_s       = m_br_pipe[1];
        ack_s      = m_ack_pipe[1];
        m_br_pipe  = {m_br_pipe[0], ~br_n};
        m_ack_pipe = {m_ack_pipe[0], ~bgack_n};
        ndone  = '0;
        nstart = 1'b0;
        ntmo   = 1'b0;
        case (m_mode)
            M_FREE: if (m_done == '0 && !eng_busy) begin
                if (ack_s) begin
                    m_mode = M_EXT; m_drive = 1'b0;
                end else if (br_s && !(m_fair && (|req))) begin
                    m_mode = M_OFFER; m_bg_n = 1'b0; m_bglow = 0;
                end else if (|req) begin
                    for (int k = 1; k <= N; k++) begin
                        int c;
                        c = (m_ptr + k) % N;
                        if (req[c[0]]) begin
                            m_idx = c;
                            break;
                        end
                    end
                    m_gnt = '0;
                    m_gnt[m_idx[0]] = 1'b1;
                    m_ptr  = m_idx;
                    m_fair = 1'b0;
                    nstart = 1'b1;
                    m_mode = M_CYCLE;
                end
            end
            M_CYCLE: if (eng_done) begin
                ndone[m_idx[0]] = 1'b1;
                if (req_lock[m_idx[0]]) m_mode = M_HELD;
                else begin m_gnt = '0; m_mode = M_FREE; end
            end
            M_HELD: begin
                if (req[m_idx[0]] && !m_done[m_idx[0]]) begin
                    nstart = 1'b1; m_mode = M_CYCLE;
                end else if (!req_lock[m_idx[0]]) begin
                    m_gnt = '0; m_mode = M_FREE;
                end
            end
            M_OFFER: begin
                m_bglow++;
                if (ack_s) begin
                    m_mode = M_EXT; m_bg_n = 1'b1; m_drive = 1'b0;
                end else if (!br_s) begin
                    m_mode = M_FREE; m_bg_n = 1'b1;
                end else if (m_bglow == TMO) begin
                    m_mode = M_FREE; m_bg_n = 1'b1; ntmo = 1'b1; m_fair = 1'b1;
                end
            end
            M_EXT: if (!ack_s) begin
                m_mode = M_FREE; m_drive = 1'b1; m_fair = 1'b1;
            end
            default: m_mode = M_FREE;
        endcase
        m_done  = ndone;
        m_start = nstart;
        m_tmo   = ntmo;
    endtask

    always @(posedge clk) begin
        if (!rst_n) model_reset();
        else model_step();
        #1;
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("gnt_idx", 32'(gnt_idx), 32'(m_idx));
        chk("done", 32'(done), 32'(m_done));
        chk("eng_start", 32'(eng_start), 32'(m_start));
        chk("bg_n", 32'(bg_n), 32'(m_bg_n));
        chk("bus_drive", 32'(bus_drive), 32'(m_drive));
        chk("bg_timeout", 32'(bg_timeout), 32'(m_tmo));
        chk("gnt_onehot0", 32'($onehot0(gnt)), 32'(1));
        chk("start_while_unowned", 32'(eng_start && !(bus_drive && bg_n)), 32'(0));
        if (eng_start) start_q.push_back(int'(gnt_idx));
        if (done != '0) done_q.push_back(done[1] ? 1 : 0);
    end

    // Acknowledge done pulses by dropping the matching request bits.
    task automatic serve(input int n, input int limit, input string tag);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < limit) begin
            @(negedge clk);
            cyc++;
            if (done != '0) begin
                seen++;
                req = req & ~done;
            end
        end
        chk({tag, "_done_count"}, 32'(seen), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=running required=finished");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int w, low, bg_seen;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_gnt", 32'(gnt), 32'(0));
        chk("rst_bg_n", 32'(bg_n), 32'(1));
        chk("rst_drive", 32'(bus_drive), 32'(1));
        chk("rst_start", 32'(eng_start), 32'(0));

        // 1: both requesters from reset, req[0] first
        rst_n = 1'b1;
        req   = 2'b11;
        @(negedge clk);
        chk("t1_first_gnt", 32'(gnt), 32'(2'b01));
        chk("t1_first_start", 32'(eng_start), 32'(1));
        @(negedge clk);
        chk("t1_start_one_cycle", 32'(eng_start), 32'(0));
        serve(2, 60, "t1");
        chk("t1_starts", 32'(start_q.size()), 32'(2));
        chk("t1_second_idx", 32'((start_q.size() > 1) ? start_q[1] : -1), 32'(1));
        chk("t1_done_first", 32'((done_q.size() > 0) ? done_q[0] : -1), 32'(0));
        chk("t1_done_second", 32'((done_q.size() > 1) ? done_q[1] : -1), 32'(1));
        repeat (3) @(negedge clk);

        // 2: external master handshake
        br_n = 1'b0;
        @(negedge clk); chk("t2_bg_c1", 32'(bg_n), 32'(1));
        @(negedge clk); chk("t2_bg_c2", 32'(bg_n), 32'(1));
        @(negedge clk); chk("t2_bg_c3", 32'(bg_n), 32'(0));
        bgack_n = 1'b0;
        br_n    = 1'b1;
        repeat (3) @(negedge clk);
        chk("t2_bg_released", 32'(bg_n), 32'(1));
        chk("t2_drive_off", 32'(bus_drive), 32'(0));
        repeat (4) @(negedge clk);
        bgack_n = 1'b1;
        @(negedge clk); chk("t2_drive_c1", 32'(bus_drive), 32'(0));
        @(negedge clk); chk("t2_drive_c2", 32'(bus_drive), 32'(0));
        @(negedge clk); chk("t2_drive_c3", 32'(bus_drive), 32'(1));
        repeat (3) @(negedge clk);

        // 3: grant never acknowledged -> timeout
        br_n = 1'b0;
        w = 0;
        while (bg_n !== 1'b0 && w < 10) begin @(negedge clk); w++; end
        chk("t3_bg_asserted", 32'(bg_n), 32'(0));
        low = 1;
        while (low < 400) begin
            @(negedge clk);
            if (bg_n === 1'b0) low++;
            else break;
        end
        chk("t3_bg_low_cycles", 32'(low), 32'(TMO));
        chk("t3_timeout_pulse", 32'(bg_timeout), 32'(1));
        br_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("t3_bg_idle", 32'(bg_n), 32'(1));
        chk("t3_timeout_cleared", 32'(bg_timeout), 32'(0));

        // 4: locked pair of cycles for requester 0 while BR is pending
        start_q.delete();
        done_q.delete();
        req      = 2'b01;
        req_lock = 2'b01;
        @(negedge clk);
        chk("t4_gnt", 32'(gnt), 32'(2'b01));
        br_n    = 1'b0;
        bg_seen = 0;
        w = 0;
        while (done[0] !== 1'b1 && w < 30) begin
            @(negedge clk); w++;
            if (bg_n === 1'b0) bg_seen++;
        end
        req[0] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bg_n === 1'b0) bg_seen++;
        end
        chk("t4_lock_hold_gnt", 32'(gnt), 32'(2'b01));
        req[0] = 1'b1;
        w = 0;
        while (done[0] !== 1'b1 && w < 30) begin
            @(negedge clk); w++;
            if (bg_n === 1'b0) bg_seen++;
        end
        req[0]      = 1'b0;
        req_lock[0] = 1'b0;
        chk("t4_no_bg_during_lock", 32'(bg_seen), 32'(0));
        chk("t4_starts", 32'(start_q.size()), 32'(2));
        w = 0;
        while (bg_n !== 1'b0 && w < 10) begin @(negedge clk); w++; end
        chk("t4_bg_after_unlock", 32'(bg_n), 32'(0));
        bgack_n = 1'b0;
        w = 0;
        while (bus_drive !== 1'b0 && w < 10) begin @(negedge clk); w++; end
        chk("t4_ext_owns", 32'(bus_drive), 32'(0));

        // 5: BR still pending after tenure, req[1] arrives -> internal goes first
        start_q.delete();
        req = 2'b10;
        repeat (3) @(negedge clk);
        chk("t5_hold_while_ext", 32'(start_q.size()), 32'(0));
        bgack_n = 1'b1;
        w = 0;
        while (gnt === 2'b00 && bg_n === 1'b1 && w < 10) begin @(negedge clk); w++; end
        chk("t5_internal_first_gnt", 32'(gnt), 32'(2'b10));
        chk("t5_bg_still_high", 32'(bg_n), 32'(1));
        serve(1, 30, "t5");
        w = 0;
        while (bg_n !== 1'b0 && w < 10) begin @(negedge clk); w++; end
        chk("t5_br_served_after", 32'(bg_n), 32'(0));
        bgack_n = 1'b0;
        br_n    = 1'b1;
        repeat (5) @(negedge clk);
        bgack_n = 1'b1;
        repeat (5) @(negedge clk);

        // 7: unsolicited BGACK while idle blocks internal starts
        start_q.delete();
        bgack_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("t7_drive_off", 32'(bus_drive), 32'(0));
        chk("t7_bg_high", 32'(bg_n), 32'(1));
        req = 2'b01;
        repeat (4) @(negedge clk);
        chk("t7_no_start", 32'(start_q.size()), 32'(0));
        bgack_n = 1'b1;
        serve(1, 30, "t7");
        repeat (3) @(negedge clk);

        // 6: asynchronous reset in the middle of a cycle
        done_q.delete();
        start_q.delete();
        req = 2'b01;
        w = 0;
        while (gnt !== 2'b01 && w < 10) begin @(negedge clk); w++; end
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_gnt", 32'(gnt), 32'(0));
        chk("t6_rst_bg_n", 32'(bg_n), 32'(1));
        chk("t6_rst_drive", 32'(bus_drive), 32'(1));
        chk("t6_rst_done", 32'(done), 32'(0));
        req = 2'b00;
        repeat (3) @(negedge clk);
        chk("t6_no_done", 32'(done_q.size()), 32'(0));
        start_q.delete();
        rst_n = 1'b1;
        req   = 2'b11;
        @(negedge clk);
        chk("t6_ptr_reset_first", 32'((start_q.size() > 0) ? start_q[0] : -1), 32'(0));
        serve(2, 60, "t6");
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
